// File: rtl/stage_out_fifo_pkg.sv
// Shared types and sizing constants for the stage output FIFO.
package stage_out_fifo_pkg;

   typedef logic [31:0] float_24_8;

   typedef struct packed {
      logic      fst;
      float_24_8 data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   // Skid must absorb every word still in flight in the stage pipeline, plus one.
   localparam int STAGE_PIPE_DEPTH = 12;
   localparam int SKID_DEFAULT     = STAGE_PIPE_DEPTH + 1;
   localparam int DEPTH_DEFAULT    = 32;

endpackage

// File: rtl/stage_out_fifo_if.sv
// Word stream with first-of-burst flag and ready/valid handshake.
interface stage_out_fifo_if;
   import stage_out_fifo_pkg::*;

   float_24_8 data;
   logic      vld;
   logic      fst;
   logic      rdy;

   modport master (output data, output vld, output fst, input  rdy);
   modport slave  (input  data, input  vld, input  fst, output rdy);

endinterface

// File: rtl/stage_out_fifo_sync_fifo_fwft.sv
// First-word fall-through FIFO; level counts the output register as an entry.
module sync_fifo_fwft #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             rvld,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam int LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      lvl_q;
   logic [WIDTH-1:0] out_q;
   logic             vld_q;
   logic             mem_empty;
   logic             load_bypass;
   logic             load_mem;
   logic             mem_wr;

   // The memory only holds words behind the output register, so a push that
   // finds the register free (or being vacated with nothing queued) skips it.
   assign mem_empty   = (lvl_q - LVL_W'(vld_q)) == '0;
   assign load_bypass = push & (~vld_q | (pop & mem_empty));
   assign load_mem    = pop & ~mem_empty;
   assign mem_wr      = push & ~load_bypass;

   assign rdata = out_q;
   assign rvld  = vld_q;
   assign level = lvl_q;
   assign full  = (lvl_q == LVL_W'(DEPTH));
   assign empty = (lvl_q == '0);

   always_ff @(posedge clk) begin
      if (mem_wr)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl_q  <= '0;
         out_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         lvl_q <= lvl_q + LVL_W'(push) - LVL_W'(pop);
         if (mem_wr)
            wr_ptr <= wr_ptr + AW'(1);
         if (load_bypass) begin
            out_q <= wdata;
            vld_q <= 1'b1;
         end else if (load_mem) begin
            out_q  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
            vld_q  <= 1'b1;
         end else if (pop) begin
            vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/stage_out_fifo.sv
// Skid buffer behind the stage controller: FWFT FIFO, in_rdy throttle,
// burst alignment checker, sticky error flags and delivered-frame counter.
module stage_out_fifo
   import stage_out_fifo_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int SKID  = SKID_DEFAULT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   stage_out_fifo_if.slave         in_bus,
   stage_out_fifo_if.master        out_bus,
   input  logic [2:0]              frame_length,
   output logic [AW:0]             level,
   output logic                    overflow,
   output logic                    fst_err,
   input  logic                    err_clr,
   output logic [7:0]              frame_cnt
);

   localparam int LVL_W = AW + 1;

   fifo_entry_t wr_entry;
   fifo_entry_t rd_entry;
   logic        rd_vld;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic        in_rdy_q;
   logic [2:0]  fcnt;
   logic        fst_bad;
   logic        ovf_set;

   // in_vld is deliberately not gated by in_rdy: words already in the
   // upstream pipeline must be taken whenever there is room.
   assign pop      = rd_vld & out_bus.rdy;
   assign push     = in_bus.vld & (~full | pop);
   assign ovf_set  = in_bus.vld & full & ~pop;
   assign fst_bad  = push & (in_bus.fst != (fcnt == 3'd0));
   assign wr_entry = '{fst: in_bus.fst, data: in_bus.data};

   assign in_bus.rdy   = in_rdy_q;
   assign out_bus.vld  = rd_vld;
   assign out_bus.fst  = rd_entry.fst;
   assign out_bus.data = rd_entry.data;

   sync_fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (rd_entry),
      .rvld  (rd_vld),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         in_rdy_q <= 1'b1;
      else
         in_rdy_q <= empty | (level <= LVL_W'(DEPTH - SKID));
   end

   // A flagged word always resyncs the position; the checker never rewrites flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fcnt <= 3'd0;
      end else if (push) begin
         if (in_bus.fst)
            fcnt <= (frame_length == 3'd0) ? 3'd0 : 3'd1;
         else if (fcnt == frame_length)
            fcnt <= 3'd0;
         else
            fcnt <= fcnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         fst_err   <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         if (ovf_set)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (fst_bad)
            fst_err <= 1'b1;
         else if (err_clr)
            fst_err <= 1'b0;
         if (pop & rd_entry.fst)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule
